// File: rtl/key_debounce.sv
// Per-key push-button conditioner: 2-flop synchroniser, polarity fix, counter debounce, press/release strobes.
// Define KEY_DEBOUNCE_AUTOREPEAT_EN to add hold-to-repeat press strobes.
module key_debounce #(
    parameter int KEYS_W          = 4,
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1,
    parameter int REPEAT_DELAY    = 25_000_000,
    parameter int REPEAT_PERIOD   = 5_000_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [KEYS_W-1:0] keys_raw_i,
    output logic [KEYS_W-1:0] keys_o,
    output logic [KEYS_W-1:0] press_o,
    output logic [KEYS_W-1:0] release_o
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [KEYS_W-1:0] REL_RAW  = {KEYS_W{KEY_ACTIVE_LOW}};

    if (DEBOUNCE_CYCLES < 1 || REPEAT_PERIOD < 1 || REPEAT_DELAY < 1) begin : g_bad_param
        $error("key_debounce: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
    end

    logic [KEYS_W-1:0] sync1;
    logic [KEYS_W-1:0] sync2;
    logic [KEYS_W-1:0] sample;
    logic [KEYS_W-1:0] accept;
    logic [KEYS_W-1:0] keys_next;
    logic [KEYS_W-1:0] press_next;
    logic [KEYS_W-1:0] release_next;
    logic [CNT_W-1:0]  cnt      [KEYS_W];
    logic [CNT_W-1:0]  cnt_next [KEYS_W];

    // Synchronisers reset to the idle pin level so a key held through reset is seen as a new press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1 <= REL_RAW;
            sync2 <= REL_RAW;
        end else begin
            sync1 <= keys_raw_i;
            sync2 <= sync1;
        end
    end

    always_comb begin
        sample = sync2 ^ REL_RAW;
        accept = '0;
        for (int k = 0; k < KEYS_W; k++) begin
            cnt_next[k] = '0;
            if (sample[k] != keys_o[k]) begin
                if (cnt[k] == CNT_LAST) begin
                    accept[k] = 1'b1;
                end else begin
                    cnt_next[k] = cnt[k] + 1'b1;
                end
            end
        end
        keys_next    = keys_o ^ accept;
        release_next = accept & ~sample;
    end

`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
    localparam int               RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int               RPT_W    = $clog2(RPT_MAX + 1);
    localparam logic [RPT_W-1:0] DELAY_V  = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] PERIOD_V = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0]  rpt      [KEYS_W];
    logic [RPT_W-1:0]  rpt_next [KEYS_W];
    logic [KEYS_W-1:0] rep_on;
    logic [KEYS_W-1:0] rep_on_next;
    logic [KEYS_W-1:0] fire;

    // rpt holds cycles since the last press strobe; the first gap uses the delay, later gaps the period.
    always_comb begin
        fire        = '0;
        rep_on_next = '0;
        for (int k = 0; k < KEYS_W; k++) begin
            logic [RPT_W-1:0] dist;
            logic [RPT_W-1:0] target;
            dist        = (press_o[k] ? '0 : rpt[k]) + 1'b1;
            target      = rep_on[k] ? PERIOD_V : DELAY_V;
            rpt_next[k] = '0;
            if (keys_o[k]) begin
                fire[k]        = (dist == target) && keys_next[k];
                rpt_next[k]    = dist;
                rep_on_next[k] = rep_on[k] | fire[k];
            end
        end
        press_next = (accept & sample) | fire;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rep_on <= '0;
            for (int k = 0; k < KEYS_W; k++) begin
                rpt[k] <= '0;
            end
        end else begin
            rep_on <= rep_on_next;
            for (int k = 0; k < KEYS_W; k++) begin
                rpt[k] <= rpt_next[k];
            end
        end
    end
`else
    always_comb begin
        press_next = accept & sample;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            keys_o    <= '0;
            press_o   <= '0;
            release_o <= '0;
            for (int k = 0; k < KEYS_W; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            keys_o    <= keys_next;
            press_o   <= press_next;
            release_o <= release_next;
            for (int k = 0; k < KEYS_W; k++) begin
                cnt[k] <= cnt_next[k];
            end
        end
    end

endmodule

// File: tb/tb_key_debounce.sv
// Randomised scoreboard bench for key_debounce against a sliding-window reference model.
// Honours KEY_DEBOUNCE_AUTOREPEAT_EN to model repeat strobes.
module tb_key_debounce;

    localparam int KW     = 4;
    localparam int DEB    = 4;
    localparam int RDELAY = 10;
    localparam int RPER   = 3;

    typedef struct {
        logic [KW-1:0] k;
        logic [KW-1:0] p;
        logic [KW-1:0] r;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [KW-1:0] raw = '0;
    logic [KW-1:0] keys;
    logic [KW-1:0] press;
    logic [KW-1:0] rel;

    int assertions = 0;
    int failures   = 0;

    exp_t          exp_q [$];
    logic [KW-1:0] pipe_q [$];
    logic [KW-1:0] s_hist [$];
    logic [KW-1:0] m_keys;
    int            cyc;
    int            acc_time [KW];

    key_debounce #(
        .KEYS_W         (KW),
        .DEBOUNCE_CYCLES(DEB),
        .KEY_ACTIVE_LOW (1'b1),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .keys_raw_i(raw),
        .keys_o    (keys),
        .press_o   (press),
        .release_o (rel)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [KW-1:0] act, input logic [KW-1:0] expv);
        assertions++;
        if (act !== expv) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", name, $time, act, expv);
        end
    endtask

    function automatic void modelReset();
        m_keys = '0;
        cyc    = 0;
        pipe_q = '{};
        s_hist = '{};
        pipe_q.push_back('0);
        pipe_q.push_back('0);
        for (int k = 0; k < KW; k++) acc_time[k] = 0;
    endfunction

    // A key flips when its pressed-sample disagreed with the held level on each of the last DEB edges.
    function automatic exp_t modelStep(input logic [KW-1:0] raw_v);
        exp_t          e;
        logic [KW-1:0] s;
        logic [KW-1:0] old_keys;
        bit            flip;
        int            since;
        pipe_q.push_back(~raw_v);
        s = pipe_q.pop_front();
        s_hist.push_back(s);
        if (s_hist.size() > DEB) void'(s_hist.pop_front());
        cyc++;
        old_keys = m_keys;
        e.p = '0;
        e.r = '0;
        for (int k = 0; k < KW; k++) begin
            flip = (s_hist.size() == DEB);
            foreach (s_hist[i]) if (s_hist[i][k] == old_keys[k]) flip = 0;
            if (flip) begin
                m_keys[k] = ~old_keys[k];
                if (m_keys[k]) begin
                    e.p[k]      = 1'b1;
                    acc_time[k] = cyc;
                end else begin
                    e.r[k] = 1'b1;
                end
            end
`ifdef KEY_DEBOUNCE_AUTOREPEAT_EN
            else if (old_keys[k]) begin
                since = cyc - acc_time[k];
                if (since == RDELAY || (since > RDELAY && (since - RDELAY) % RPER == 0))
                    e.p[k] = 1'b1;
            end
`else
            since = 0;
`endif
        end
        e.k = m_keys;
        return e;
    endfunction

    task automatic applyStimulus(input logic [KW-1:0] raw_v, input logic rst_v, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            raw = raw_v;
            if (!rst_v) begin
                if (rst_n) begin
                    rst_n = 1'b0;
                    #1;
                    checkOutput("async_reset_keys", keys, '0);
                    checkOutput("async_reset_press", press, '0);
                    checkOutput("async_reset_release", rel, '0);
                end
                rst_n = 1'b0;
                modelReset();
                e.k = '0;
                e.p = '0;
                e.r = '0;
            end else begin
                rst_n = 1'b1;
                e = modelStep(raw_v);
            end
            exp_q.push_back(e);
        end
    endtask

    // Monitor: one expected record per clock edge, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("keys", keys, e.k);
                checkOutput("press", press, e.p);
                checkOutput("release", rel, e.r);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [KW-1:0] r;
        modelReset();
        // All keys held through reset, then released from reset.
        applyStimulus(4'b0000, 1'b0, 3);
        applyStimulus(4'b0000, 1'b1, 10);
        applyStimulus(4'b1111, 1'b1, 10);
        // Single key press and release.
        applyStimulus(4'b1110, 1'b1, 10);
        applyStimulus(4'b1111, 1'b1, 10);
        // Glitches of 1, 2, 3 cycles, then an accepted 4-cycle pulse.
        for (int w = 1; w <= 4; w++) begin
            applyStimulus(4'b1101, 1'b1, w);
            applyStimulus(4'b1111, 1'b1, 1);
        end
        applyStimulus(4'b1111, 1'b1, 10);
        // Two keys together, then reset in the middle of key 0 counting.
        applyStimulus(4'b0011, 1'b1, 8);
        applyStimulus(4'b0010, 1'b1, 4);
        applyStimulus(4'b0010, 1'b0, 3);
        applyStimulus(4'b0010, 1'b1, 10);
        applyStimulus(4'b1111, 1'b1, 10);
        // Long hold on key 0 (repeats when enabled).
        applyStimulus(4'b1110, 1'b1, 6 + 30);
        applyStimulus(4'b1111, 1'b1, 12);
        // Random bouncing on all keys with one reset in the middle.
        r = 4'b1111;
        for (int i = 0; i < 600; i++) begin
            for (int k = 0; k < KW; k++)
                if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
            applyStimulus(r, (i == 300) ? 1'b0 : 1'b1, (i == 300) ? 2 : 1);
        end
        applyStimulus(4'b1111, 1'b1, 12);
        repeat (3) @(posedge clk);
        #2;
        assertions++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
